// File: rtl/brq_pkg.sv
// Package for the branch resolve queue.
// Holds the default widths, the instruction size used for the
// fall-through PC and the logical layout of one queue entry.
package brq_pkg;

  localparam int BRQ_PC_W   = 32;
  localparam int BRQ_IDX_W  = 8;
  localparam int INSN_BYTES = 4;

  // Logical entry layout at the default PC width. Storage keeps the same
  // field order {pc, pred_taken, pred_target} as a flat vector so that
  // non-default PC_W values still work.
  typedef struct packed {
    logic [BRQ_PC_W-1:0] pc;
    logic                pred_taken;
    logic [BRQ_PC_W-1:0] pred_target;
  } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue_storage.sv
// brq_storage: DEPTH-entry register array for the branch resolve queue.
// Ports: clk; we/waddr/wdata single write port; raddr/rdata
// combinational read (used for the head entry).
module brq_storage #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 65,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [PTR_W-1:0]   waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [PTR_W-1:0]   raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  // Entry payload needs no reset: occupancy is tracked by the count register.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of in-flight predicted branches.
// Fetch enqueues (enq_*); execute resolves the oldest (res_*). Each fired
// resolve produces a registered predictor update (upd_*) one cycle later
// and, on a mispredict, a one-cycle flush pulse with redirect_pc.
// count reports occupancy; enq_ready = not full (from registered count).
// Optional build macro BRQ_STATS_EN adds stat_resolved / stat_mispred
// saturating 32-bit counters.
// Reset: rst, synchronous, active-high.
module branch_resolve_queue
  import brq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = BRQ_PC_W,
  parameter int IDX_W = BRQ_IDX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq_valid,
  input  logic [PC_W-1:0]        enq_pc,
  input  logic                   enq_pred_taken,
  input  logic [PC_W-1:0]        enq_pred_target,
  output logic                   enq_ready,
  input  logic                   res_valid,
  input  logic                   res_taken,
  input  logic [PC_W-1:0]        res_target,
  output logic                   upd_valid,
  output logic [IDX_W-1:0]       upd_addr,
  output logic                   upd_taken,
  output logic                   mispredict,
  output logic [PC_W-1:0]        redirect_pc,
  output logic [$clog2(DEPTH):0] count
`ifdef BRQ_STATS_EN
  ,
  output logic [31:0]            stat_resolved,
  output logic [31:0]            stat_mispred
`endif
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 2 * PC_W + 1;

  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               upd_valid_q, upd_valid_d;
  logic [IDX_W-1:0]   upd_addr_q, upd_addr_d;
  logic               upd_taken_q, upd_taken_d;
  logic               mispredict_q, mispredict_d;
  logic [PC_W-1:0]    redirect_pc_q, redirect_pc_d;

  logic               enq_fire, res_fire, mis, we;
  logic [ENTRY_W-1:0] head_entry, wdata;
  logic [PC_W-1:0]    h_pc, h_target, correct_pc;
  logic               h_taken;

  brq_storage #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .PTR_W(PTR_W)) u_storage (
    .clk   (clk),
    .we    (we),
    .waddr (tail_q),
    .wdata (wdata),
    .raddr (head_q),
    .rdata (head_entry)
  );

  assign wdata    = {enq_pc, enq_pred_taken, enq_pred_target};
  assign h_pc     = head_entry[ENTRY_W-1 -: PC_W];
  assign h_taken  = head_entry[PC_W];
  assign h_target = head_entry[PC_W-1:0];

  assign enq_ready = (count_q != CNT_W'(DEPTH));
  assign enq_fire  = enq_valid && enq_ready;
  assign res_fire  = res_valid && (count_q != {CNT_W{1'b0}});

  // A not-taken prediction's target is irrelevant, so only compare targets
  // when the branch was actually taken.
  assign mis = res_fire &&
               ((res_taken != h_taken) || (res_taken && (res_target != h_target)));
  assign correct_pc = res_taken ? res_target : (h_pc + PC_W'(INSN_BYTES));

  // Wrong-path enqueues are dropped in the flush cycle.
  assign we = enq_fire && !mis;

  // Next-state for pointers, occupancy and the registered update outputs.
  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    upd_valid_d   = res_fire;
    upd_addr_d    = upd_addr_q;
    upd_taken_d   = upd_taken_q;
    mispredict_d  = mis;
    redirect_pc_d = redirect_pc_q;
    if (res_fire) begin
      upd_addr_d  = h_pc[IDX_W-1:0];
      upd_taken_d = res_taken;
    end else begin
      upd_addr_d  = upd_addr_q;
    end
    if (mis) begin
      head_d        = tail_q;
      count_d       = {CNT_W{1'b0}};
      redirect_pc_d = correct_pc;
    end else begin
      head_d  = head_q + PTR_W'(res_fire);
      tail_d  = tail_q + PTR_W'(enq_fire);
      count_d = count_q + CNT_W'(enq_fire) - CNT_W'(res_fire);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      upd_valid_q   <= 1'b0;
      upd_addr_q    <= '0;
      upd_taken_q   <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      upd_valid_q   <= upd_valid_d;
      upd_addr_q    <= upd_addr_d;
      upd_taken_q   <= upd_taken_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign upd_valid   = upd_valid_q;
  assign upd_addr    = upd_addr_q;
  assign upd_taken   = upd_taken_q;
  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_pc_q;
  assign count       = count_q;

`ifdef BRQ_STATS_EN
  logic [31:0] stat_resolved_q, stat_resolved_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;

  // Saturating event counters.
  always_comb begin
    stat_resolved_d = stat_resolved_q;
    stat_mispred_d  = stat_mispred_q;
    if (res_fire && (stat_resolved_q != 32'hFFFF_FFFF)) begin
      stat_resolved_d = stat_resolved_q + 32'd1;
    end
    if (mis && (stat_mispred_q != 32'hFFFF_FFFF)) begin
      stat_mispred_d = stat_mispred_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_resolved_q <= 32'd0;
      stat_mispred_q  <= 32'd0;
    end else begin
      stat_resolved_q <= stat_resolved_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_resolved = stat_resolved_q;
  assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue (DEPTH=4, PC_W=32, IDX_W=8).
// A reference queue model predicts every resolve; expected update records
// are pushed to a scoreboard when stimulus is driven and popped when the
// DUT raises upd_valid.
module tb_branch_resolve_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enq_valid = 1'b0;
  logic [31:0] enq_pc = 32'd0;
  logic        enq_pred_taken = 1'b0;
  logic [31:0] enq_pred_target = 32'd0;
  logic        enq_ready;
  logic        res_valid = 1'b0;
  logic        res_taken = 1'b0;
  logic [31:0] res_target = 32'd0;
  logic        upd_valid;
  logic [7:0]  upd_addr;
  logic        upd_taken;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [2:0]  count;
`ifdef BRQ_STATS_EN
  logic [31:0] stat_resolved;
  logic [31:0] stat_mispred;
`endif

  branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(32), .IDX_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .enq_valid       (enq_valid),
    .enq_pc          (enq_pc),
    .enq_pred_taken  (enq_pred_taken),
    .enq_pred_target (enq_pred_target),
    .enq_ready       (enq_ready),
    .res_valid       (res_valid),
    .res_taken       (res_taken),
    .res_target      (res_target),
    .upd_valid       (upd_valid),
    .upd_addr        (upd_addr),
    .upd_taken       (upd_taken),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .count           (count)
`ifdef BRQ_STATS_EN
    ,
    .stat_resolved   (stat_resolved),
    .stat_mispred    (stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    logic [7:0]  addr;
    logic        taken;
    logic        mis;
  } exp_t;

  ent_t        mq[$];
  exp_t        sb[$];
  logic [31:0] exp_redirect = 32'd0;
  int          checks = 0;
  int          errors = 0;

  // Drive one cycle, update the model, then compare the registered outputs.
  task automatic cycle(input logic r, input logic ev, input logic [31:0] pc,
                       input logic pt, input logic [31:0] tgt, input logic rv,
                       input logic rt, input logic [31:0] rtgt);
    ent_t e;
    exp_t x;
    exp_t got;
    logic ef, rf, m;
    rst = r; enq_valid = ev; enq_pc = pc; enq_pred_taken = pt; enq_pred_target = tgt;
    res_valid = rv; res_taken = rt; res_target = rtgt;
    if (r) begin
      mq.delete();
      sb.delete();
      exp_redirect = 32'd0;
    end else begin
      ef = ev && (mq.size() != DEPTH);
      rf = rv && (mq.size() != 0);
      m  = 1'b0;
      if (rf) begin
        e = mq[0];
        m = (rt != e.pt) || (rt && (rtgt != e.tgt));
        x.addr = e.pc[7:0]; x.taken = rt; x.mis = m;
        sb.push_back(x);
        if (m) exp_redirect = rt ? rtgt : e.pc + 32'd4;
      end
      if (m) begin
        mq.delete();
      end else begin
        if (rf) void'(mq.pop_front());
        if (ef) begin
          e.pc = pc; e.pt = pt; e.tgt = tgt;
          mq.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0; enq_valid = 1'b0; res_valid = 1'b0;
    checks++;
    if (upd_valid !== (sb.size() != 0)) begin
      errors++;
      $display("FAIL upd_valid: got %b want %b", upd_valid, sb.size() != 0);
    end
    if (sb.size() != 0) begin
      got = sb.pop_front();
      checks++;
      if (upd_addr !== got.addr || upd_taken !== got.taken || mispredict !== got.mis) begin
        errors++;
        $display("FAIL update: got addr=%h taken=%b mis=%b want addr=%h taken=%b mis=%b",
                 upd_addr, upd_taken, mispredict, got.addr, got.taken, got.mis);
      end
    end else begin
      checks++;
      if (mispredict !== 1'b0) begin
        errors++;
        $display("FAIL idle_mispredict: got %b want 0", mispredict);
      end
    end
    checks++;
    if (redirect_pc !== exp_redirect) begin
      errors++;
      $display("FAIL redirect_pc: got %h want %h", redirect_pc, exp_redirect);
    end
    checks++;
    if (count !== 3'(mq.size()) || enq_ready !== (mq.size() != DEPTH)) begin
      errors++;
      $display("FAIL occupancy: got count=%0d ready=%b want count=%0d ready=%b",
               count, enq_ready, mq.size(), mq.size() != DEPTH);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    checks++;
    if (upd_addr !== 8'h00 || upd_taken !== 1'b0 || count !== 3'd0 || enq_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: got addr=%h taken=%b count=%0d ready=%b want 00 0 0 1",
               upd_addr, upd_taken, count, enq_ready);
    end
    idle(10);
  endtask

  task automatic test_correct_nt();
    cycle(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (upd_valid !== 1'b1 || upd_addr !== 8'h00 || count !== 3'd0) begin
      errors++;
      $display("FAIL correct_nt: got v=%b addr=%h count=%0d want 1 00 0", upd_valid, upd_addr, count);
    end
    idle(1);
  endtask

  task automatic test_target_mispredict();
    cycle(1'b0, 1'b1, 32'h1F0, 1'b1, 32'h300, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h340);
    checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h340 || upd_taken !== 1'b1 || upd_addr !== 8'hF0) begin
      errors++;
      $display("FAIL target_mis: got mis=%b pc=%h taken=%b addr=%h want 1 340 1 f0",
               mispredict, redirect_pc, upd_taken, upd_addr);
    end
    idle(2);
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++)
      cycle(1'b0, 1'b1, 32'h10 * (i + 1), 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
    checks++;
    if (count !== 3'd4 || enq_ready !== 1'b0) begin
      errors++;
      $display("FAIL full: got count=%0d ready=%b want 4 0", count, enq_ready);
    end
    cycle(1'b0, 1'b1, 32'h99, 1'b0, 32'h0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (count !== 3'd3 || upd_addr !== 8'h10) begin
      errors++;
      $display("FAIL pop_when_full: got count=%0d addr=%h want 3 10", count, upd_addr);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'd0);
  endtask

  task automatic test_flush_drop();
    cycle(1'b0, 1'b1, 32'h200, 1'b1, 32'h280, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 32'h210, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 32'h220, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 1'b0, 32'd0);
    checks++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h204 || count !== 3'd0) begin
      errors++;
      $display("FAIL flush_drop: got mis=%b pc=%h count=%0d want 1 204 0", mispredict, redirect_pc, count);
    end
    cycle(1'b0, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'd0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 32'h400 + 32'(i * 8), 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'd0);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h123);
    idle(1);
  endtask

  task automatic test_reset_mid_flush();
    cycle(1'b0, 1'b1, 32'h600, 1'b1, 32'h700, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 32'h610, 1'b0, 32'h0, 1'b1, 1'b0, 32'd0);
    idle(1);
  endtask

  task automatic test_random();
    logic        rt;
    logic [31:0] rtgt;
    for (int i = 0; i < 80; i++) begin
      rt = $urandom_range(0, 1);
      rtgt = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      if (mq.size() != 0 && $urandom_range(0, 3) != 0) begin
        rt = mq[0].pt;
        rtgt = mq[0].tgt;
      end
      cycle(1'b0, 1'($urandom_range(0, 1)), {20'h0, 10'($urandom_range(0, 1023)), 2'b00},
            1'($urandom_range(0, 1)), {20'h0, 10'($urandom_range(0, 1023)), 2'b00},
            1'($urandom_range(0, 1)), rt, rtgt);
    end
  endtask

  initial begin
    test_reset();
    test_correct_nt();
    test_target_mispredict();
    test_full();
    test_flush_drop();
    test_wrap();
    test_reset_mid_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
